// File: rtl/div_by_12_50_dut.sv
// div_by_12_50_dut: even-ratio clock divider with a 50% duty output, plus an
// independent free-running edge counter.
//
// Parameters
//   DIV   : even division ratio, 2..254. out has a period of DIV clk cycles.
//   CNT_W : width of the free-running counter output.
//
// Ports
//   clk   : input,  single clock, all state updates on its rising edge.
//   reset : input,  asynchronous, active-low reset of all state.
//   out   : output, divided clock (DIV/2 cycles low, DIV/2 cycles high).
//   count : output, number of clk rising edges since reset release, mod 2^CNT_W.
//
// Both outputs come straight from flops. The divider and the counter share only
// clk and reset.
module div_by_12_50_dut #(
  parameter int unsigned DIV   = 12,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  output logic             out,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned Half = DIV / 2;
  // A ratio of 2 needs a single phase value; keep at least one bit of state.
  localparam int unsigned PhW  = (Half > 1) ? $clog2(Half) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(Half - 1);

  if ((DIV < 2) || (DIV > 254) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("div_by_12_50_dut: DIV must be even and within 2..254");
  end

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("div_by_12_50_dut: CNT_W must be at least 1");
  end

  // Divider state
  logic [PhW-1:0]   ph_q, ph_d;
  logic             out_q, out_d;
  // Counter state
  logic [CNT_W-1:0] count_q, count_d;

  // Divider next state: toggle out at the end of each half period. Any
  // out-of-range phase is pulled back to 0 without touching out.
  always_comb begin
    ph_d  = ph_q;
    out_d = out_q;
    if (ph_q == PhLast) begin
      ph_d  = '0;
      out_d = ~out_q;
    end else if (ph_q > PhLast) begin
      ph_d  = '0;
    end else begin
      ph_d  = ph_q + PhW'(1);
    end
  end

  // Counter next state: plain modulo-2^CNT_W increment, wraps silently.
  always_comb begin
    count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q  <= '0;
      out_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      out_q <= out_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out   = out_q;
  assign count = count_q;

endmodule

// File: tb/tb_div_by_12_50_dut.sv
`timescale 1ns / 1ps
module tb_div_by_12_50_dut;

  logic       clk;
  logic       reset;
  logic       out12;
  logic [6:0] count12;
  logic       out4;
  logic [3:0] count4;

  int unsigned vectors;
  int unsigned miscompares;
  bit          run_cmp;
  // Reference model: rising edges seen since the last reset release.
  int unsigned n_edges;

  div_by_12_50_dut #(
    .DIV   (12),
    .CNT_W (7)
  ) u_dut12 (
    .clk   (clk),
    .reset (reset),
    .out   (out12),
    .count (count12)
  );

  div_by_12_50_dut #(
    .DIV   (4),
    .CNT_W (4)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .out   (out4),
    .count (count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset never changes on a rising edge, so these two never race.
  always @(posedge clk) if (reset) n_edges = n_edges + 1;
  always @(negedge reset) n_edges = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the edge count: out is high during odd-numbered
  // half periods, count is the edge count modulo 2^W.
  function automatic int unsigned exp_out(input int unsigned n, input int unsigned div);
    return (n / (div / 2)) % 2;
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cyc_out12",   {31'd0, out12},   reset ? exp_out(n_edges, 12) : 0);
      chk("cyc_count12", {25'd0, count12}, reset ? n_edges % 128 : 0);
      chk("cyc_out4",    {31'd0, out4},    reset ? exp_out(n_edges, 4) : 0);
      chk("cyc_count4",  {28'd0, count4},  reset ? n_edges % 16 : 0);
    end
  end

  task automatic wait_edges(input int unsigned k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Offset into the cycle that stays clear of both clock edges.
  function automatic int unsigned safe_offset();
    int unsigned r;
    r = $urandom_range(1, 6);
    if (r >= 4) r = r + 2;
    return r;
  endfunction

  initial begin
    int unsigned run_len;
    int unsigned off;
    int unsigned hold;
    vectors     = 0;
    miscompares = 0;
    n_edges     = 0;
    reset       = 1'b0;
    run_cmp     = 1'b0;
    #1;
    run_cmp     = 1'b1;

    // Held in reset across 20 edges: everything stays at zero.
    wait_edges(20);
    chk("rst_hold_out12",   {31'd0, out12},   0);
    chk("rst_hold_count12", {25'd0, count12}, 0);
    #1;
    reset = 1'b1;

    // Power-up sequence, pinned with literal values.
    wait_edges(1);
    chk("edge1_count12", {25'd0, count12}, 1);
    wait_edges(4);
    chk("edge5_out12", {31'd0, out12}, 0);
    wait_edges(1);
    chk("edge6_out12",   {31'd0, out12},   1);
    chk("edge6_count12", {25'd0, count12}, 6);
    wait_edges(6);
    chk("edge12_out12", {31'd0, out12}, 0);
    wait_edges(6);
    chk("edge18_out12", {31'd0, out12}, 1);
    wait_edges(32);
    chk("edge50_count12", {25'd0, count12}, 50);
    chk("edge50_out4",    {31'd0, out4},    1);
    wait_edges(77);
    chk("edge127_count12", {25'd0, count12}, 127);
    wait_edges(1);
    chk("edge128_count12", {25'd0, count12}, 0);
    wait_edges(1);
    chk("edge129_count12", {25'd0, count12}, 1);

    // Edge 141: out12 high with phase 3. Assert reset mid-cycle.
    wait_edges(12);
    chk("edge141_out12", {31'd0, out12}, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_out12",   {31'd0, out12},   0);
    chk("async_count12", {25'd0, count12}, 0);
    chk("async_count4",  {28'd0, count4},  0);
    wait_edges(2);
    #2;
    reset = 1'b1;
    wait_edges(5);
    chk("rel_edge5_out12", {31'd0, out12}, 0);
    wait_edges(1);
    chk("rel_edge6_out12", {31'd0, out12}, 1);

    // Randomised runs separated by asynchronous reset pulses.
    for (int it = 0; it < 30; it++) begin
      run_len = $urandom_range(1, 60);
      repeat (run_len) @(posedge clk);
      off = safe_offset();
      #(off);
      reset = 1'b0;
      #1;
      chk("rnd_async_out12",   {31'd0, out12},   0);
      chk("rnd_async_count12", {25'd0, count12}, 0);
      hold = $urandom_range(1, 3);
      repeat (hold) @(posedge clk);
      off = safe_offset();
      #(off);
      reset = 1'b1;
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    run_cmp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_by_12_50_dut.md
DIV_BY_12_50_DUT -- requirements
Module: div_by_12_50_dut

Interface
REQ-001 Parameter DIV, default 12: even clock-division ratio, legal range 2..254; out period = DIV clk cycles.
REQ-002 Parameter CNT_W, default 7: width of the free-running cycle counter output.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: one clock; reset is asynchronous and active-low.
REQ-005 Port out  output  1: divided clock, period DIV clk cycles, 50% duty.
REQ-006 Port count  output  CNT_W: free-running count of clk rising edges since reset release.
REQ-007 All outputs SHALL be driven directly from flip-flops, with no combinational path from any input to any output.

Function
REQ-008 Divider state SHALL be a phase counter ph of width ceil(log2(DIV/2)) bits (3 bits for DIV=12), counting 0..DIV/2-1.
REQ-009 On each rising edge with reset=1: if ph==DIV/2-1 then ph<=0 and out<=~out; else ph<=ph+1 and out holds.
REQ-010 out SHALL therefore be high for exactly DIV/2 cycles and low for exactly DIV/2 cycles (6/6 for DIV=12), with no glitches.
REQ-011 Out toggle timing: first toggle (0->1) on the (DIV/2)th rising edge after reset release, i.e. the 6th edge for DIV=12; subsequent toggles every DIV/2 edges.
REQ-012 ph SHALL never take a value >= DIV/2; any illegal value SHALL be forced to 0 on the next edge, with out held.
REQ-013 On each rising edge with reset=1, count SHALL be replaced by count+1 modulo 2^CNT_W.
REQ-014 Wrap: count SHALL go from 127 to 0 (CNT_W=7) with no stall or flag.
REQ-015 count and the divider SHALL run independently of each other, sharing only clk and reset.
REQ-016 A rising edge coincident with reset deassertion SHALL NOT advance any state; the first counted edge is the first rising edge strictly after reset goes high.

Reset
REQ-017 While reset=0, all state SHALL be held in reset: out=0, ph=0, count=0.
REQ-018 Reset assertion SHALL take effect immediately, without waiting for a clk edge, and SHALL override any clk activity.
REQ-019 Reset asserted mid-period (e.g. out=1, ph=3) SHALL force out=0, ph=0, count=0 at once.
REQ-020 After release, behaviour SHALL restart exactly as specified from power-up (REQ-011, REQ-013).
REQ-021 No reset-free storage elements are permitted.

Verification
REQ-022 Scenario 1: clk period 2, reset=0 for 2 time units, then 1 -> out=0 and count=0 during reset; count=1,2,3... on successive rising edges after release.
REQ-023 Scenario 2: same setup, run 100 time units (50 edges) -> out rises on edge 6, falls on edge 12, rises on edge 18, and so on; every high/low interval is 6 edges; count reads 50 at the end.
REQ-024 Scenario 3: run 130 edges after release -> count passes 127 then 0 then 1 on consecutive edges.
REQ-025 Scenario 4: assert reset asynchronously between edges while out=1, ph=3 -> out=0 and count=0 immediately, before the next edge; after release, out rises again on the 6th edge.
REQ-026 Scenario 5: DIV=4, CNT_W=4 -> out toggles every 2 edges (period 4, 2/2 duty); count wraps 15->0.
REQ-027 Scenario 6: hold reset=0 and toggle clk for 20 edges -> out, count and ph stay 0 throughout.
